// File: rtl/btn_pkg.sv
// Shared state encoding and default cycle counts for the button debouncer.
// Latency: none (types and constants only); no backpressure.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } btn_state_t;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 100_000_000;

endpackage

// File: rtl/btn_db_channel.sv
// One button channel: 2-flop sync, debounce FSM, edge pulses, long-press if BTN_LONGPRESS_EN.
// Latency: level/pulse DEBOUNCE_CYC+2 cycles after a clean input edge; no backpressure.
module btn_db_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_pulse
);

    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          rise_nxt;
    logic          fall_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // The counter tracks consecutive samples of the candidate level; it leaves WAIT at terminal count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync2) begin
                    state_nxt = S_WAIT_HI;
                    cnt_nxt   = CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (!sync2) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_HIGH: begin
                if (!sync2) begin
                    state_nxt = S_WAIT_LO;
                    cnt_nxt   = CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (sync2) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    if (DEBOUNCE_CYC < 2 || LONG_CYC < 2) begin : g_bad_param_range
    end

`ifdef BTN_LONGPRESS_EN
    localparam int            HW        = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYC);

    logic [HW-1:0] hold_cnt;

    // Parking at LONG_CYC (one past the trigger value) guarantees a single pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if ((state == S_WAIT_HI && state_nxt == S_HIGH) || state_nxt == S_LOW) begin
                hold_cnt <= '0;
            end else if (state == S_HIGH || state == S_WAIT_LO) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt   <= HOLD_SAT;
                    long_pulse <= 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_edge.sv
// N_CH independent debounced button channels with rise/fall pulses (long-press via BTN_LONGPRESS_EN).
// Latency: DEBOUNCE_CYC+2 cycles from clean input edge to level/pulse; no backpressure.
module btn_debounce_edge
    import btn_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN_IN,
    output logic [N_CH-1:0] BTN_LEVEL,
    output logic [N_CH-1:0] BTN_RISE,
    output logic [N_CH-1:0] BTN_FALL,
    output logic [N_CH-1:0] BTN_LONG
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_db_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .clk        (CLK),
            .rst        (RST),
            .din        (BTN_IN[i]),
            .level      (BTN_LEVEL[i]),
            .rise       (BTN_RISE[i]),
            .fall       (BTN_FALL[i]),
            .long_pulse (BTN_LONG[i])
        );
    end

endmodule
